// File: rtl/postproc_denorm.sv
// postproc_denorm
// Restores a left-justified normalized word to its original magnitude by a
// right shift of shift_in bits, with optional round-half-up and saturation
// to DATA_WIDTH bits. Two-stage valid/ready pipeline, one sample per cycle.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset, clears all state
//   in_valid     norm_in / shift_in valid
//   in_ready     block accepts an input this cycle (combinational on out_ready)
//   norm_in      normalized word, NORM_WIDTH bits
//   shift_in     right-shift amount, SHIFT_WIDTH bits
//   out_valid    data_out valid
//   out_ready    downstream accepts data_out
//   data_out     restored sample, DATA_WIDTH bits
//   sat_flag     data_out was saturated (qualified by out_valid)
//   clear        synchronous clear of both counters
//   sample_count output handshakes, wraps
//   sat_count    saturated output handshakes, sticks at all-ones
module postproc_denorm #(
  parameter int DATA_WIDTH  = 16,
  parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH),
  parameter int NORM_WIDTH  = DATA_WIDTH + SHIFT_WIDTH,
  parameter int ROUND       = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NORM_WIDTH-1:0]  norm_in,
  input  logic [SHIFT_WIDTH-1:0] shift_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   sat_flag,
  input  logic                   clear,
  output logic [CNT_WIDTH-1:0]   sample_count,
  output logic [CNT_WIDTH-1:0]   sat_count
);

  // Stage 1 registers
  logic                   s1_valid;
  logic [NORM_WIDTH-1:0]  s1_norm;
  logic [SHIFT_WIDTH-1:0] s1_shift;

  // Pipeline advance
  logic s2_load;
  logic s1_load;
  logic out_hs;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;
  assign out_hs   = out_valid && out_ready;

  // Stage 2 arithmetic, one guard bit above NORM_WIDTH for the round carry
  logic [NORM_WIDTH:0]   shifted;
  logic [NORM_WIDTH:0]   rounded;
  logic                  round_bit;
  logic                  s2_sat;
  logic [DATA_WIDTH-1:0] s2_data;

  always_comb begin
    shifted   = {1'b0, s1_norm} >> s1_shift;
    round_bit = 1'b0;
    if ((ROUND != 0) && (s1_shift != '0))
      round_bit = s1_norm[s1_shift - 1'b1];
    rounded   = shifted + {{NORM_WIDTH{1'b0}}, round_bit};
    // Anything at or above bit DATA_WIDTH means the value does not fit
    s2_sat    = |rounded[NORM_WIDTH:DATA_WIDTH];
    s2_data   = s2_sat ? '1 : rounded[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_norm  <= '0;
      s1_shift <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_norm  <= norm_in;
        s1_shift <= shift_in;
      end
    end
  end

  // data_out/sat_flag only change when a real sample moves in, so they hold
  // through stalls and bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      sat_flag  <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        data_out <= s2_data;
        sat_flag <= s2_sat;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_count <= '0;
      sat_count    <= '0;
    end else if (clear) begin
      sample_count <= '0;
      sat_count    <= '0;
    end else if (out_hs) begin
      sample_count <= sample_count + 1'b1;
      if (sat_flag && (sat_count != '1))
        sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_postproc_denorm.sv
module tb_postproc_denorm;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [19:0] norm_in;
  logic [3:0]  shift_in;
  logic        out_ready;
  logic        clear;

  logic        in_ready_a, out_valid_a, sat_flag_a;
  logic [15:0] data_out_a;
  logic [3:0]  sample_count_a, sat_count_a;

  logic        in_ready_b, out_valid_b, sat_flag_b;
  logic [15:0] data_out_b;
  logic [15:0] sample_count_b, sat_count_b;

  always #5 clk = ~clk;

  // A: rounding, narrow counters.  B: truncating, full-width counters.
  postproc_denorm #(.DATA_WIDTH(16), .ROUND(1), .CNT_WIDTH(4)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .norm_in(norm_in), .shift_in(shift_in), .out_valid(out_valid_a),
    .out_ready(out_ready), .data_out(data_out_a), .sat_flag(sat_flag_a),
    .clear(clear), .sample_count(sample_count_a), .sat_count(sat_count_a)
  );

  postproc_denorm #(.DATA_WIDTH(16), .ROUND(0), .CNT_WIDTH(16)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .norm_in(norm_in), .shift_in(shift_in), .out_valid(out_valid_b),
    .out_ready(out_ready), .data_out(data_out_b), .sat_flag(sat_flag_b),
    .clear(clear), .sample_count(sample_count_b), .sat_count(sat_count_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: divide by 2^s, round half-up on the remainder, clamp.
  function automatic logic [16:0] ref_out(input logic [19:0] n, input logic [3:0] s, input bit rnd);
    longint unsigned nv, dv, q, r;
    nv = n;
    dv = 64'd1 << s;
    q  = nv / dv;
    r  = nv % dv;
    if (rnd && s != 0 && r >= dv / 2) q++;
    if (q > 65535) return {1'b1, 16'hFFFF};
    return {1'b0, q[15:0]};
  endfunction

  typedef struct { logic [19:0] n; logic [3:0] s; } item_t;
  item_t q_inflight[$];

  int unsigned m_cnt_a, m_sat_a, m_cnt_b, m_sat_b;

  task automatic model_clear();
    q_inflight.delete();
    m_cnt_a = 0; m_sat_a = 0; m_cnt_b = 0; m_sat_b = 0;
  endtask

  // One clock cycle: drive after the falling edge, check before the rising
  // edge, then advance the model on the rising edge.
  task automatic step(input logic iv, input logic [19:0] n, input logic [3:0] s,
                      input logic ordy, input logic clr, output bit acc);
    bit in_hs, out_hs;
    logic [16:0] ea, eb;
    @(negedge clk);
    in_valid = iv; norm_in = n; shift_in = s; out_ready = ordy; clear = clr;
    #1;
    check("cnt_a", {28'd0, sample_count_a}, m_cnt_a);
    check("sat_cnt_a", {28'd0, sat_count_a}, m_sat_a);
    check("cnt_b", {16'd0, sample_count_b}, m_cnt_b);
    check("sat_cnt_b", {16'd0, sat_count_b}, m_sat_b);
    check("in_ready_a", {31'd0, in_ready_a}, {31'd0, (q_inflight.size() < 2) || ordy});
    check("in_ready_b", {31'd0, in_ready_b}, {31'd0, in_ready_a});
    check("out_valid_b", {31'd0, out_valid_b}, {31'd0, out_valid_a});
    check("ov_without_item", {31'd0, out_valid_a && q_inflight.size() == 0}, 32'd0);
    in_hs  = iv && in_ready_a;
    out_hs = out_valid_a && ordy;
    ea = '0; eb = '0;
    if (out_valid_a && q_inflight.size() > 0) begin
      ea = ref_out(q_inflight[0].n, q_inflight[0].s, 1'b1);
      eb = ref_out(q_inflight[0].n, q_inflight[0].s, 1'b0);
      check("data_a", {16'd0, data_out_a}, {16'd0, ea[15:0]});
      check("sat_a", {31'd0, sat_flag_a}, {31'd0, ea[16]});
      check("data_b", {16'd0, data_out_b}, {16'd0, eb[15:0]});
      check("sat_b", {31'd0, sat_flag_b}, {31'd0, eb[16]});
    end
    @(posedge clk);
    if (clr) begin
      m_cnt_a = 0; m_sat_a = 0; m_cnt_b = 0; m_sat_b = 0;
    end else if (out_hs) begin
      m_cnt_a = (m_cnt_a + 1) % 16;
      m_cnt_b = (m_cnt_b + 1) % 65536;
      if (ea[16] && m_sat_a < 15) m_sat_a++;
      if (eb[16] && m_sat_b < 65535) m_sat_b++;
    end
    if (out_hs && q_inflight.size() > 0) void'(q_inflight.pop_front());
    if (in_hs) begin
      item_t it;
      it.n = n; it.s = s;
      q_inflight.push_back(it);
    end
    acc = in_hs;
  endtask

  task automatic drain();
    bit acc;
    int unsigned k = 0;
    while (q_inflight.size() > 0 && k < 20) begin
      step(1'b0, '0, '0, 1'b1, 1'b0, acc);
      k++;
    end
    check("drain_timeout", q_inflight.size(), 32'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0, acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int unsigned idx;
    logic [19:0] bp_n [6];
    logic [3:0]  bp_s [6];

    reset = 1'b1; in_valid = 1'b0; norm_in = '0; shift_in = '0;
    out_ready = 1'b0; clear = 1'b0;
    model_clear();
    #3;
    check("rst_in_ready", {31'd0, in_ready_a}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
    check("rst_data", {16'd0, data_out_a}, 32'd0);
    check("rst_sat", {31'd0, sat_flag_a}, 32'd0);
    check("rst_cnt", {28'd0, sample_count_a}, 32'd0);
    check("rst_satcnt", {28'd0, sat_count_a}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Latency and basic restore
    step(1'b1, 20'h08000, 4'd3, 1'b1, 1'b0, acc);
    check("lat_acc", {31'd0, acc}, 32'd1);
    #1;
    check("lat_ov_first_edge", {31'd0, out_valid_a}, 32'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0, acc);
    #1;
    check("lat_ov_second_edge", {31'd0, out_valid_a}, 32'd1);
    check("lat_data", {16'd0, data_out_a}, 32'h1000);
    check("lat_sat", {31'd0, sat_flag_a}, 32'd0);
    drain();

    // Saturation at shift 0
    step(1'b1, 20'hFFFFF, 4'd0, 1'b1, 1'b0, acc);
    drain();
    #1;
    check("sat_cnt_one", {28'd0, sat_count_a}, 32'd1);

    // Rounding and round-carry saturation, back to back
    step(1'b1, 20'h0000C, 4'd3, 1'b1, 1'b0, acc);
    step(1'b1, 20'h0000B, 4'd3, 1'b1, 1'b0, acc);
    step(1'b1, 20'h1FFFF, 4'd1, 1'b1, 1'b0, acc);
    step(1'b1, 20'h00000, 4'd7, 1'b1, 1'b0, acc);
    drain();

    // Backpressure: 6 offered, 5 stalled cycles
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bp_n[i] = 20'($urandom);
      bp_s[i] = 4'($urandom);
    end
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, bp_n[idx], bp_s[idx], 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    check("bp_accepted", idx, 32'd2);
    #1;
    check("bp_in_ready_low", {31'd0, in_ready_a}, 32'd0);
    for (int c = 0; c < 20 && idx < 6; c++) begin
      step(1'b1, bp_n[idx], bp_s[idx], 1'b1, 1'b0, acc);
      if (acc) idx++;
    end
    check("bp_all_offered", idx, 32'd6);
    drain();
    #1;
    check("bp_count6", {16'd0, sample_count_b}, 32'd6);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 3) != 0), 20'($urandom), 4'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0), acc);
    end
    drain();

    // Asynchronous reset with both stages full
    step(1'b1, 20'hFFFFF, 4'd0, 1'b1, 1'b0, acc);
    step(1'b1, 20'h12345, 4'd2, 1'b0, 1'b0, acc);
    step(1'b1, 20'h54321, 4'd4, 1'b0, 1'b0, acc);
    check("mid_full", q_inflight.size(), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check("mid_out_valid", {31'd0, out_valid_a}, 32'd0);
    check("mid_data", {16'd0, data_out_a}, 32'd0);
    check("mid_cnt_a", {28'd0, sample_count_a}, 32'd0);
    check("mid_satcnt_a", {28'd0, sat_count_a}, 32'd0);
    check("mid_cnt_b", {16'd0, sample_count_b}, 32'd0);
    check("mid_in_ready", {31'd0, in_ready_a}, 32'd1);
    model_clear();
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) step(1'b0, '0, '0, 1'b1, 1'b0, acc);

    // Counter wrap and stick
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b1, 20'($urandom_range(0, 20'hFFFF)), 4'd0, 1'b1, 1'b0, acc);
    drain();
    #1;
    check("cnt_wrap17", {28'd0, sample_count_a}, 32'd1);
    for (int i = 0; i < 20; i++) step(1'b1, 20'hFFFFF, 4'd0, 1'b1, 1'b0, acc);
    drain();
    #1;
    check("sat_stick15", {28'd0, sat_count_a}, 32'd15);
    check("sat_b20", {16'd0, sat_count_b}, 32'd20);

    // Clear coinciding with a handshake
    step(1'b1, 20'hFFFFF, 4'd0, 1'b0, 1'b0, acc);
    step(1'b0, '0, '0, 1'b0, 1'b0, acc);
    step(1'b0, '0, '0, 1'b1, 1'b1, acc);
    #1;
    check("clr_cnt_a", {28'd0, sample_count_a}, 32'd0);
    check("clr_sat_a", {28'd0, sat_count_a}, 32'd0);
    check("clr_cnt_b", {16'd0, sample_count_b}, 32'd0);
    check("clr_sat_b", {16'd0, sat_count_b}, 32'd0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
